// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The helper wraps a requester index with an explicit compare so non-power-of-two counts work.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_STREAM
  } uart_arb_state;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Round-robin priority picker: first set request at or above rr_ptr, wrapping.
// Purely combinational; shared by any arbiter that needs a rotating priority.
module rr_priority_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               pick_valid
);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick[idx]  = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter byte port.
// An owner keeps the transmitter until a last-flagged byte or MAX_PACKET bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = UART_BYTE_W,
  parameter int unsigned MAX_PACKET = 64
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ-1:0]            req_last_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [DATA_WIDTH-1:0]         tx_data_out,
  output logic                          tx_valid_out,
  input  logic                          tx_ready_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic                          busy_out
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_PACKET);

  uart_arb_state      state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   byte_count_q, byte_count_d;

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               streaming;
  logic               owner_valid;
  logic               owner_last;
  logic               xfer;
  logic               pkt_end;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req        (req_valid_in),
    .rr_ptr     (rr_ptr_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign streaming = (state_q == ARB_STREAM);

  // Owner path is a pure one-hot mux on the registered grant: no added latency,
  // and everything collapses to zero the instant reset clears the grant.
  always_comb begin
    tx_data_out = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        tx_data_out = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        owner_valid = req_valid_in[i];
        owner_last  = req_last_in[i];
      end
    end
  end

  assign tx_valid_out  = streaming & owner_valid;
  assign req_ready_out = streaming ? (grant_q & {NUM_REQ{tx_ready_in}}) : '0;
  assign grant_out     = grant_q;
  assign busy_out      = streaming;

  assign xfer    = tx_valid_out & tx_ready_in;
  assign pkt_end = owner_last || (byte_count_q == CNT_W'(MAX_PACKET - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    byte_count_d = byte_count_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d      = ARB_STREAM;
          grant_d      = pick;
          owner_d      = pick_idx;
          byte_count_d = '0;
        end
      end
      ARB_STREAM: begin
        if (xfer) begin
          if (pkt_end) begin
            state_d      = ARB_IDLE;
            grant_d      = '0;
            byte_count_d = '0;
            rr_ptr_d     = PTR_W'(rr_next(32'(owner_q), NUM_REQ));
          end else begin
            byte_count_d = byte_count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      byte_count_q <= byte_count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester/transmitter models feed a
// scoreboard of expected {grant, byte} transfers checked at the falling edge.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [NR*DW-1:0]  req_data_in = '0;
  logic [NR-1:0]     req_valid_in = '0;
  logic [NR-1:0]     req_last_in = '0;
  logic [NR-1:0]     req_ready_out;
  logic [DW-1:0]     tx_data_out;
  logic              tx_valid_out;
  logic              tx_ready_in = 1'b0;
  logic [NR-1:0]     grant_out;
  logic              busy_out;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_PACKET (4)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_data_in   (req_data_in),
    .req_valid_in  (req_valid_in),
    .req_last_in   (req_last_in),
    .req_ready_out (req_ready_out),
    .tx_data_out   (tx_data_out),
    .tx_valid_out  (tx_valid_out),
    .tx_ready_in   (tx_ready_in),
    .grant_out     (grant_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Requester byte stores: {last, data}
  logic [8:0]  rmem [NR][64];
  int          head [NR];
  int          tail [NR];
  logic [NR-1:0] fire = '0;

  logic [11:0] expq [$];
  logic [3:0]  glog [$];
  int          gaps [$];
  logic [3:0]  prev_g = '0;
  int          zero_cnt = 0;

  int tx_mode = 0;   // 0 always ready, 1 one pulse per 40 cycles, 2 held low
  int pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Transmitter ready model
  always @(posedge clk_in) begin
    #1;
    case (tx_mode)
      0: tx_ready_in = 1'b1;
      1: begin
        pulse_cnt   = (pulse_cnt == 39) ? 0 : pulse_cnt + 1;
        tx_ready_in = (pulse_cnt == 39);
      end
      default: tx_ready_in = 1'b0;
    endcase
  end

  // Requester models: advance on an accepted byte, hold data until then
  always @(posedge clk_in) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) head[i]++;
      if (head[i] != tail[i]) begin
        req_valid_in[i]          = 1'b1;
        req_data_in[i*DW +: DW]  = rmem[i][head[i]][7:0];
        req_last_in[i]           = rmem[i][head[i]][8];
      end else begin
        req_valid_in[i] = 1'b0;
        req_last_in[i]  = 1'b0;
      end
    end
    fire = '0;
  end

  // Monitor: scoreboard pop on each transfer, grant-order and gap log
  always @(negedge clk_in) begin
    logic [11:0] e;
    if (rst_in) begin
      fire = '0;
    end else begin
      fire = req_valid_in & req_ready_out;
      if (tx_valid_out && tx_ready_in) begin
        e = (expq.size() != 0) ? expq.pop_front() : 12'hFFF;
        chk("xfer", {grant_out, tx_data_out}, {20'h0, e});
      end
      if (grant_out != 0 && grant_out != prev_g) begin
        glog.push_back(grant_out);
        gaps.push_back(zero_cnt);
        zero_cnt = 0;
      end
      if (grant_out == 0) zero_cnt++;
      prev_g = grant_out;
    end
  end

  task automatic nclk(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic enq(input int r, input logic [7:0] d, input logic last);
    rmem[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  task automatic expect_x(input int r, input logic [7:0] d);
    logic [3:0] oh;
    oh = 4'(1 << r);
    expq.push_back({oh, d});
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] g, input int budget);
    for (int k = 0; k < budget && grant_out !== g; k++) nclk(1);
    chk(tag, grant_out, g);
  endtask

  task automatic wait_drained(input string tag, input int budget);
    for (int k = 0; k < budget && expq.size() != 0; k++) nclk(1);
    chk(tag, expq.size(), 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget && !(expq.size() == 0 && grant_out == 0); k++) nclk(1);
    chk({tag, "_drained"}, expq.size(), 0);
    chk({tag, "_grant0"}, grant_out, 0);
  endtask

  function automatic logic [3:0] glog_at(input int i);
    return (i < glog.size()) ? glog[i] : 4'hF;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_seq [5];
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Reset state
    nclk(2);
    chk("rst_grant_held", grant_out, 0);
    @(posedge clk_in); #3; rst_in = 1'b0;
    nclk(1);
    chk("rst_grant", grant_out, 0);
    chk("rst_txv", tx_valid_out, 0);
    chk("rst_ready", req_ready_out, 0);
    chk("rst_data", tx_data_out, 0);
    chk("rst_busy", busy_out, 0);

    // Single packet with a slow transmitter
    tx_mode = 1;
    enq(1, 8'h48, 1'b0); expect_x(1, 8'h48);
    enq(1, 8'h49, 1'b1); expect_x(1, 8'h49);
    nclk(1);
    chk("single_valid_seen", req_valid_in, 4'b0010);
    chk("single_pre_grant", grant_out, 0);
    nclk(1);
    chk("single_grant", grant_out, 4'b0010);
    chk("single_busy", busy_out, 1);
    wait_idle("single", 300);

    // rr_ptr left at 2: req2 must win over req0
    tx_mode = 0;
    glog.delete(); gaps.delete();
    enq(0, 8'hB0, 1'b1);
    enq(2, 8'hC0, 1'b1);
    expect_x(2, 8'hC0);
    expect_x(0, 8'hB0);
    wait_idle("rrptr", 50);
    chk("rrptr_first", glog_at(0), 4'b0100);
    chk("rrptr_second", glog_at(1), 4'b0001);

    // Backpressure: ready low for 500 cycles
    tx_mode = 2;
    nclk(1);
    enq(0, 8'hA5, 1'b1); expect_x(0, 8'hA5);
    wait_grant("bp_grant", 4'b0001, 10);
    for (int k = 0; k < 500; k++) begin
      nclk(1);
      if (k % 50 == 0) begin
        chk("bp_txv", tx_valid_out, 1);
        chk("bp_data", tx_data_out, 8'hA5);
        chk("bp_ready", req_ready_out, 0);
      end
    end
    chk("bp_no_xfer", expq.size(), 1);
    tx_mode = 0;
    nclk(1);
    chk("bp_first_ready", expq.size(), 0);
    wait_idle("bp", 20);

    // Forced release after MAX_PACKET=4 bytes
    glog.delete(); gaps.delete();
    for (int b = 0; b < 6; b++) begin
      enq(2, 8'(8'h20 + b), (b == 5));
      if (b < 4) expect_x(2, 8'(8'h20 + b));
    end
    wait_grant("fr_grant", 4'b0100, 10);
    enq(0, 8'h30, 1'b1);
    enq(1, 8'h40, 1'b0);
    enq(1, 8'h41, 1'b1);
    expect_x(0, 8'h30);
    expect_x(1, 8'h40);
    expect_x(1, 8'h41);
    expect_x(2, 8'h24);
    expect_x(2, 8'h25);
    wait_idle("fr", 100);
    chk("fr_g0", glog_at(0), 4'b0100);
    chk("fr_g1", glog_at(1), 4'b0001);
    chk("fr_g2", glog_at(2), 4'b0010);
    chk("fr_g3", glog_at(3), 4'b0100);

    // Owner stall: req3 goes quiet mid-packet while req0 waits
    enq(3, 8'h50, 1'b0); expect_x(3, 8'h50);
    wait_grant("stall_grant", 4'b1000, 10);
    wait_drained("stall_first", 10);
    enq(0, 8'h60, 1'b1);
    nclk(2);
    for (int k = 0; k < 100; k++) begin
      chk("stall_grant_hold", grant_out, 4'b1000);
      chk("stall_txv", tx_valid_out, 0);
      chk("stall_ready0", req_ready_out[0], 0);
      nclk(1);
    end
    enq(3, 8'h51, 1'b1);
    expect_x(3, 8'h51);
    expect_x(0, 8'h60);
    wait_idle("stall", 50);

    // Async reset mid-packet (rr_ptr now 1)
    enq(1, 8'h70, 1'b0); expect_x(1, 8'h70);
    wait_grant("ar_grant", 4'b0010, 10);
    wait_drained("ar_first", 10);
    chk("ar_pre_ready", req_ready_out, 4'b0010);
    @(posedge clk_in); #3;
    rst_in = 1'b1;
    #1;
    chk("ar_grant", grant_out, 0);
    chk("ar_txv", tx_valid_out, 0);
    chk("ar_ready", req_ready_out, 0);
    chk("ar_busy", busy_out, 0);
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    expq.delete();
    nclk(1);
    @(posedge clk_in); #3;
    rst_in = 1'b0;
    nclk(1);

    // Round-robin from index 0 after reset, all requesters continuously valid
    glog.delete(); gaps.delete();
    enq(0, 8'h80, 1'b0); enq(0, 8'h81, 1'b1);
    enq(1, 8'h90, 1'b0); enq(1, 8'h91, 1'b1);
    enq(2, 8'hA0, 1'b0); enq(2, 8'hA1, 1'b1);
    enq(3, 8'hB0, 1'b0); enq(3, 8'hB1, 1'b1);
    enq(0, 8'h82, 1'b0); enq(0, 8'h83, 1'b1);
    expect_x(0, 8'h80); expect_x(0, 8'h81);
    expect_x(1, 8'h90); expect_x(1, 8'h91);
    expect_x(2, 8'hA0); expect_x(2, 8'hA1);
    expect_x(3, 8'hB0); expect_x(3, 8'hB1);
    expect_x(0, 8'h82); expect_x(0, 8'h83);
    wait_idle("rr", 100);
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_grant%0d", i), glog_at(i), rr_seq[i]);
      if (i > 0) chk($sformatf("rr_gap%0d", i), gap_at(i), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter byte stream between NUM_REQ independent requesters (debug printers, memory dumpers, status reporters).
- Uses round-robin arbitration at packet granularity. A granted requester keeps the transmitter until it hands over a byte flagged last, so multi-byte messages are never interleaved.
- Sits directly in front of the transmitter's data/valid/ready port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, byte width passed to the transmitter.
- MAX_PACKET, 64, maximum bytes per grant. The grant is force-released after this many bytes even without a last flag.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- req_data_in  input  NUM_REQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid_in  input  NUM_REQ  requester i presents a byte.
- req_last_in  input  NUM_REQ  requester i byte is the final byte of its packet.
- req_ready_out  output  NUM_REQ  requester i byte accepted this cycle when valid and ready are both high.
- tx_data_out  output  DATA_WIDTH  byte to the transmitter.
- tx_valid_out  output  1  byte valid to the transmitter.
- tx_ready_in  input  1  transmitter idle and able to accept.
- grant_out  output  NUM_REQ  one-hot current owner; all zero when no requester owns the transmitter.
- busy_out  output  1  high while the arbiter is in STREAM.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, grant = 0, rr_ptr = 0, byte_count = 0.
  - All outputs 0; tx_data_out = 0.
- Handshake: a transfer occurs on a rising edge where valid and ready are both high, on either side. Data is held stable by the requester until accepted.
- State IDLE:
  - tx_valid_out = 0, req_ready_out = 0, grant_out = 0.
  - If any req_valid_in is set, pick the first set bit searching from index rr_ptr upward with wrap-around.
  - Register grant (one-hot) and go to STREAM.
  - Arbitration latency: exactly 1 cycle from req_valid to grant_out.
- State STREAM, owner g:
  - tx_data_out = req_data_in[g], tx_valid_out = req_valid_in[g], req_ready_out[g] = tx_ready_in. This path is combinational, with no added latency.
  - All other req_ready_out bits are 0.
  - On each transfer, byte_count increments.
  - On a transfer with req_last_in[g] = 1, or with byte_count == MAX_PACKET-1: go to IDLE, set rr_ptr = (g+1) mod NUM_REQ, clear byte_count and grant.
  - Owner dropping valid mid-packet: the grant is kept and the arbiter waits indefinitely, with no timeout.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,3,0,...
  - There is one IDLE cycle between packets.
  - A requester waits at most NUM_REQ-1 packets.
- Simultaneous events:
  - New requests arriving while in STREAM are ignored until IDLE.
  - Request bits that drop before being granted are simply not selected.
- req_last_in on a non-granted requester is ignored.
- Width rules:
  - byte_count is $clog2(MAX_PACKET) bits.
  - rr_ptr is $clog2(NUM_REQ) bits; wrap uses an explicit compare for non-power-of-two NUM_REQ.
- Reset mid-packet: the grant drops immediately (asynchronous) and tx_valid_out goes 0. A byte already latched by the transmitter completes on its own, since this block does not control that.

Decomposition:
- A shared package uart_pkg holds:
  - the typedef enum {ARB_IDLE, ARB_STREAM} uart_arb_state;
  - the constant UART_BYTE_W = 8.
- Sub-module rr_priority_picker (NUM_REQ): combinational, takes req vector and rr_ptr, returns a one-hot pick plus a valid flag. It is reusable by other arbiters in the design.

Test Plan:
- Single packet:
  - Stimulus: req1 sends 0x48,0x49(last); other requesters idle; transmitter model asserts ready every 40 cycles.
  - Required response: grant_out = 0010 one cycle after valid; tx sees 0x48 then 0x49; grant returns to 0000; rr_ptr = 2.
- Round-robin:
  - Stimulus: req0..req3 all continuously valid with 2-byte packets.
  - Required response: grant sequence 0001,0010,0100,1000,0001; no byte interleaving; one IDLE cycle between packets.
- Forced release:
  - Stimulus: MAX_PACKET = 4; req2 streams 6 bytes without last.
  - Required response: after 4 transfers, grant drops; req2 is re-granted only after other pending requesters.
- Owner stall:
  - Stimulus: req3 drops valid for 100 cycles mid-packet while req0 is valid.
  - Required response: grant stays 1000; tx_valid_out = 0 throughout; req_ready_out[0] = 0.
- Async reset mid-packet:
  - Stimulus: assert rst_in between clock edges during STREAM.
  - Required response: grant_out, tx_valid_out and req_ready_out go 0 before the next edge; after release, arbitration restarts at index 0.
- Backpressure:
  - Stimulus: tx_ready_in held low for 500 cycles with req0 valid.
  - Required response: no transfer occurs; req0 data is held; the transfer completes on the first cycle ready returns.
